// File: rtl/fifo_stimulus_loopback_if.sv
// Handshake bundle for the stimulus source (FIFO read port) and the checking sink
// (FIFO write port). The slave modport is the block itself; the master drives it.
interface fifo_stimulus_loopback_if #(
  parameter int BYTE_WIDTH = 14
);
  logic                    rd_en;
  logic                    rd_valid;
  logic [BYTE_WIDTH*8-1:0] rd_data;
  logic                    rd_empty;
  logic                    wr_en;
  logic [BYTE_WIDTH*8-1:0] wr_data;
  logic                    wr_ack;
  logic                    wr_full;
  logic                    done;
  logic [15:0]             error_count;
  logic                    overflow;

  modport master (
    output rd_en, wr_en, wr_data,
    input  rd_valid, rd_data, rd_empty, wr_ack, wr_full, done, error_count, overflow
  );

  modport slave (
    input  rd_en, wr_en, wr_data,
    output rd_valid, rd_data, rd_empty, wr_ack, wr_full, done, error_count, overflow
  );
endinterface

// File: rtl/fifo_stimulus_loopback.sv
// Pattern source and pattern-checking sink with FIFO-style ports. The source emits
// NUM_WORDS words of pattern(i); the sink checks them in order under periodic backpressure.
module fifo_stimulus_loopback #(
  parameter int BYTE_WIDTH = 14,
  parameter int NUM_WORDS  = 256,
  parameter int FULL_EVERY = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  fifo_stimulus_loopback_if.slave bus
);

  localparam int          DW       = BYTE_WIDTH * 8;
  localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS);
  localparam int          BPW      = (FULL_EVERY > 1) ? $clog2(FULL_EVERY) : 1;
  localparam logic [BPW-1:0] BP_TOP = BPW'((FULL_EVERY > 0) ? (FULL_EVERY - 1) : 0);
  localparam bit          BP_ON    = (FULL_EVERY != 0);

  // Byte k of word idx is (idx + k) mod 256; 8-bit addition gives the modulo for free.
  function automatic logic [DW-1:0] pattern(input logic [15:0] idx);
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < BYTE_WIDTH; k++) begin
      w[8*k +: 8] = idx[7:0] + 8'(k);
    end
    return w;
  endfunction

  logic [15:0]    src_idx;
  logic [15:0]    exp_idx;
  logic [BPW-1:0] bp_cnt;
  logic           wr_ack;
  logic [15:0]    error_count;
  logic           overflow;

  logic           rd_empty;
  logic           rd_valid;
  logic [DW-1:0]  rd_data;
  logic           done;
  logic           wr_full;
  logic           rd_take;
  logic           wr_take;
  logic           wr_drop;
  logic           wr_bad;

  // Status and data decode from the index registers and current requests.
  always_comb begin
    rd_empty = (src_idx == LAST_IDX);
    rd_valid = ~rd_empty;
    if (rd_empty) begin
      rd_data = '0;
    end else begin
      rd_data = pattern(src_idx);
    end
    done    = (exp_idx == LAST_IDX);
    wr_full = done | (BP_ON & (bp_cnt == BP_TOP));
    rd_take = bus.rd_en & ~rd_empty;
    wr_take = bus.wr_en & ~wr_full;
    wr_drop = bus.wr_en & wr_full;
    wr_bad  = (bus.wr_data != pattern(exp_idx));
  end

  // Source read index; requests against an exhausted source are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_idx <= 16'd0;
    end else if (rd_take) begin
      src_idx <= src_idx + 16'd1;
    end else begin
      src_idx <= src_idx;
    end
  end

  // Free-running backpressure phase counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_cnt <= '0;
    end else if (!BP_ON || (bp_cnt == BP_TOP)) begin
      bp_cnt <= '0;
    end else begin
      bp_cnt <= bp_cnt + BPW'(1);
    end
  end

  // Sink: accept, compare against expected word, flag dropped writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_idx     <= 16'd0;
      wr_ack      <= 1'b0;
      error_count <= 16'd0;
      overflow    <= 1'b0;
    end else begin
      wr_ack <= wr_take;
      if (wr_take) begin
        exp_idx <= exp_idx + 16'd1;
      end else begin
        exp_idx <= exp_idx;
      end
      if (wr_take && wr_bad && (error_count != 16'hFFFF)) begin
        error_count <= error_count + 16'd1;
      end else begin
        error_count <= error_count;
      end
      if (wr_drop) begin
        overflow <= 1'b1;
      end else begin
        overflow <= overflow;
      end
    end
  end

  assign bus.rd_empty    = rd_empty;
  assign bus.rd_valid    = rd_valid;
  assign bus.rd_data     = rd_data;
  assign bus.done        = done;
  assign bus.wr_full     = wr_full;
  assign bus.wr_ack      = wr_ack;
  assign bus.error_count = error_count;
  assign bus.overflow    = overflow;

endmodule

// File: tb/tb_fifo_stimulus_loopback.sv
// Directed bench: reset values, source stepping, sink error counting, backpressure,
// NUM_WORDS=4 boundaries, full loopback and reset mid-transfer.
module tb_fifo_stimulus_loopback;
  localparam int BW = 14;
  localparam int DW = BW * 8;
  localparam logic [DW-1:0] P0 = 112'h0d0c0b0a09080706050403020100;
  localparam logic [DW-1:0] P3 = 112'h100f0e0d0c0b0a09080706050403;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_stimulus_loopback_if #(.BYTE_WIDTH(BW)) a_bus ();
  fifo_stimulus_loopback_if #(.BYTE_WIDTH(BW)) b_bus ();

  logic          loop_a = 1'b0;
  logic          a_rd_en = 1'b0, a_wr_en = 1'b0;
  logic [DW-1:0] a_wr_data = '0;
  logic          b_rd_en = 1'b0, b_wr_en = 1'b0;
  logic [DW-1:0] b_wr_data = '0;

  // Loopback mode: write only what the source offers while the sink is not full.
  assign a_bus.rd_en   = loop_a ? ~a_bus.wr_full : a_rd_en;
  assign a_bus.wr_en   = loop_a ? (a_bus.rd_valid & ~a_bus.wr_full) : a_wr_en;
  assign a_bus.wr_data = loop_a ? a_bus.rd_data : a_wr_data;
  assign b_bus.rd_en   = b_rd_en;
  assign b_bus.wr_en   = b_wr_en;
  assign b_bus.wr_data = b_wr_data;

  fifo_stimulus_loopback #(.BYTE_WIDTH(BW), .NUM_WORDS(256), .FULL_EVERY(8)) dut (
    .clk(clk), .rst(rst), .bus(a_bus)
  );
  fifo_stimulus_loopback #(.BYTE_WIDTH(BW), .NUM_WORDS(4), .FULL_EVERY(0)) dut4 (
    .clk(clk), .rst(rst), .bus(b_bus)
  );

  int errors = 0;
  int checks = 0;

  function automatic logic [DW-1:0] pat(input int i);
    logic [DW-1:0] w;
    for (int k = 0; k < BW; k++) w[8*k +: 8] = 8'((i + k) % 256);
    return w;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_rd_valid"}, 128'(a_bus.rd_valid), 128'(1));
    check({tag, "_rd_empty"}, 128'(a_bus.rd_empty), 128'(0));
    check({tag, "_rd_data"}, 128'(a_bus.rd_data), 128'(P0));
    check({tag, "_done"}, 128'(a_bus.done), 128'(0));
    check({tag, "_wr_full"}, 128'(a_bus.wr_full), 128'(0));
    check({tag, "_wr_ack"}, 128'(a_bus.wr_ack), 128'(0));
    check({tag, "_err"}, 128'(a_bus.error_count), 128'(0));
    check({tag, "_ovf"}, 128'(a_bus.overflow), 128'(0));
  endtask

  // Pulse reset away from clock edges and release on a falling edge.
  task automatic reset_pulse();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_loop(input string tag);
    int acks = 0;
    int cyc = 0;
    while (a_bus.done !== 1'b1 && cyc < 295) begin
      @(negedge clk);
      cyc++;
      if (a_bus.wr_ack === 1'b1) acks++;
    end
    check({tag, "_done"}, 128'(a_bus.done), 128'(1));
    check({tag, "_acks"}, 128'(acks), 128'(256));
    check({tag, "_err"}, 128'(a_bus.error_count), 128'(0));
    check({tag, "_ovf"}, 128'(a_bus.overflow), 128'(0));
    check({tag, "_empty"}, 128'(a_bus.rd_empty), 128'(1));
    check({tag, "_full"}, 128'(a_bus.wr_full), 128'(1));
  endtask

  initial begin
    logic [DW-1:0] bad;
    logic [DW-1:0] rd;
    int acks;
    int cyc;

    // Reset state
    repeat (2) @(negedge clk);
    chk_reset("rst0");
    check("rst0_b_rd_data", 128'(b_bus.rd_data), 128'(P0));
    check("rst0_b_rd_valid", 128'(b_bus.rd_valid), 128'(1));

    // Source alone: three reads
    rst = 1'b0;
    a_rd_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("src_step", 128'(a_bus.rd_data), 128'(pat(i)));
      check("src_no_ack", 128'(a_bus.wr_ack), 128'(0));
    end
    a_rd_en = 1'b0;
    @(negedge clk);
    rd = a_bus.rd_data;
    check("src_hold_p3", 128'(rd), 128'(P3));
    check("src_p3_byte0", 128'(rd[7:0]), 128'(8'h03));
    check("src_p3_byte13", 128'(rd[111:104]), 128'(8'h10));

    // Sink with one corrupted word
    reset_pulse();
    a_wr_en = 1'b1;
    a_wr_data = pat(0);
    @(negedge clk);
    check("sink_ack0", 128'(a_bus.wr_ack), 128'(1));
    check("sink_err0", 128'(a_bus.error_count), 128'(0));
    bad = pat(1);
    bad[7:0] = 8'hFF;
    a_wr_data = bad;
    @(negedge clk);
    check("sink_ack1", 128'(a_bus.wr_ack), 128'(1));
    check("sink_err1", 128'(a_bus.error_count), 128'(1));
    a_wr_en = 1'b0;
    @(negedge clk);
    check("sink_ack_idle", 128'(a_bus.wr_ack), 128'(0));
    a_wr_en = 1'b1;
    a_wr_data = pat(2);
    @(negedge clk);
    check("sink_ack2", 128'(a_bus.wr_ack), 128'(1));
    check("sink_err_idx2", 128'(a_bus.error_count), 128'(1));
    check("sink_ovf", 128'(a_bus.overflow), 128'(0));
    a_wr_en = 1'b0;

    // Backpressure: wr_en held from reset release
    reset_pulse();
    a_wr_en = 1'b1;
    a_wr_data = '0;
    for (int c = 0; c < 24; c++) begin
      check("bp_full", 128'(a_bus.wr_full), 128'((c % 8) == 7));
      check("bp_ack", 128'(a_bus.wr_ack), 128'((c > 0) && (((c - 1) % 8) != 7)));
      check("bp_ovf", 128'(a_bus.overflow), 128'(c >= 8));
      @(negedge clk);
    end
    a_wr_en = 1'b0;

    // NUM_WORDS=4 boundary on the second instance
    b_rd_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("b_rd_empty", 128'(b_bus.rd_empty), 128'(i == 4));
    end
    check("b_rd_valid", 128'(b_bus.rd_valid), 128'(0));
    check("b_rd_data_zero", 128'(b_bus.rd_data), 128'(0));
    @(negedge clk);
    check("b_no_wrap_empty", 128'(b_bus.rd_empty), 128'(1));
    check("b_no_wrap_valid", 128'(b_bus.rd_valid), 128'(0));
    b_rd_en = 1'b0;
    b_wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_wr_data = pat(i);
      check("b_not_full", 128'(b_bus.wr_full), 128'(0));
      check("b_not_done", 128'(b_bus.done), 128'(0));
      @(negedge clk);
      check("b_ack", 128'(b_bus.wr_ack), 128'(1));
    end
    check("b_done", 128'(b_bus.done), 128'(1));
    check("b_done_full", 128'(b_bus.wr_full), 128'(1));
    check("b_err", 128'(b_bus.error_count), 128'(0));
    check("b_ovf_before", 128'(b_bus.overflow), 128'(0));
    @(negedge clk);
    check("b_drop_ack", 128'(b_bus.wr_ack), 128'(0));
    check("b_ovf_after", 128'(b_bus.overflow), 128'(1));
    b_wr_en = 1'b0;

    // Full loopback with defaults
    reset_pulse();
    loop_a = 1'b1;
    run_loop("loop1");

    // Reset after 10 words, then a full run
    loop_a = 1'b0;
    reset_pulse();
    loop_a = 1'b1;
    acks = 0;
    cyc = 0;
    while (acks < 10 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (a_bus.wr_ack === 1'b1) acks++;
    end
    check("mid_acks", 128'(acks), 128'(10));
    check("mid_ack_high", 128'(a_bus.wr_ack), 128'(1));
    #2 rst = 1'b1;
    #1 chk_reset("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    run_loop("loop2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_stimulus_loopback.md
FIFO_STIMULUS_LOOPBACK -- requirements
Module: fifo_stimulus_loopback

Interface
REQ-001 The block SHALL have parameter BYTE_WIDTH, default 14, giving the data word width in bytes (data width = BYTE_WIDTH*8 bits).
REQ-002 The block SHALL have parameter NUM_WORDS, default 256, range 1..65535, giving the words the source emits and the sink expects.
REQ-003 The block SHALL have parameter FULL_EVERY, default 8, giving the sink backpressure period in cycles; 0 disables backpressure.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  the single clock; all registers update on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 rd_en  input  1  source read request, FIFO read-port style.
REQ-008 rd_valid  output  1  source word available on rd_data.
REQ-009 rd_data  output  BYTE_WIDTH*8  source data word.
REQ-010 rd_empty  output  1  source exhausted.
REQ-011 wr_en  input  1  sink write request, FIFO write-port style.
REQ-012 wr_data  input  BYTE_WIDTH*8  sink data word.
REQ-013 wr_ack  output  1  sink accepted a write on the previous edge.
REQ-014 wr_full  output  1  sink refuses writes this cycle.
REQ-015 done  output  1  sink has accepted NUM_WORDS words.
REQ-016 error_count  output  16  saturating count of mismatched accepted words.
REQ-017 overflow  output  1  sticky flag: a write was attempted while wr_full was high.

Function
REQ-018 pattern(i), for word index i, SHALL have byte k (bits 8k+7..8k, k=0..BYTE_WIDTH-1) equal to (i+k) mod 256.
REQ-019 The source SHALL hold a 16-bit index src_idx; rd_empty SHALL be (src_idx == NUM_WORDS) and rd_valid SHALL be ~rd_empty, both combinational from registers.
REQ-020 rd_data SHALL be pattern(src_idx) combinationally (first-word-fall-through); it is don't-care while rd_empty, but the design SHALL drive all zeros then.
REQ-021 On an edge with rd_en=1 and rd_empty=0, src_idx SHALL increment by 1.
REQ-022 rd_en while rd_empty=1 SHALL be ignored, with no index change and no wrap.
REQ-023 The sink SHALL hold a 16-bit index exp_idx, and done SHALL be (exp_idx == NUM_WORDS).
REQ-024 Backpressure counter bp_cnt SHALL count 0..FULL_EVERY-1 and wrap every cycle.
REQ-025 wr_full SHALL be 1 when done=1, or when FULL_EVERY≠0 and bp_cnt==FULL_EVERY-1; otherwise wr_full SHALL be 0.
REQ-026 On an edge with wr_en=1 and wr_full=0, the write SHALL be accepted: exp_idx increments, and wr_ack is 1 for the next cycle.
REQ-027 On an accepted write where wr_data≠pattern(exp_idx), error_count SHALL increment, saturating at 65535.
REQ-028 On an edge with wr_en=1 and wr_full=1, the write SHALL be dropped: no index change, wr_ack=0 next cycle, and overflow set to 1 until reset.
REQ-029 wr_ack SHALL be 0 in every cycle not following an accepted write.
REQ-030 Source and sink SHALL be independent; loopback (wr_en=rd_valid, wr_data=rd_data, rd_en=~wr_full) SHALL move one word per edge when both sides agree, with zero latency and no overflow.
REQ-031 Simultaneous source advance and sink accept on one edge SHALL both take effect.

Reset
REQ-032 While rst=1, regardless of clk: src_idx=0, exp_idx=0, bp_cnt=0, wr_ack=0, error_count=0, overflow=0.
REQ-033 Consequently, in reset rd_valid=1, rd_empty=0, rd_data=pattern(0), and done=0; wr_full=0 unless FULL_EVERY==1.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer immediately, and the sequence SHALL restart from word 0 after release.

Verification
REQ-035 Loopback, defaults: after reset release, done=1 within 256+ceil(256/7)+2 cycles, with error_count=0, overflow=0, and exactly 256 wr_ack pulses.
REQ-036 Source alone: pulse rd_en 3 times; rd_data SHALL step pattern(0)->pattern(3), where pattern(3) byte0=0x03 and byte13=0x10.
REQ-037 Sink with corrupted data: write pattern(0), then a word with byte0=0xFF in place of pattern(1); error_count=1, exp_idx=2, and two wr_ack pulses.
REQ-038 Sink with FULL_EVERY=8: hold wr_en=1 from reset; wr_full SHALL be high at cycles 7, 15, ..., overflow=1 after cycle 7, and those writes not acknowledged.
REQ-039 Boundary, NUM_WORDS=4: after 4 reads rd_empty=1 and rd_valid=0, a further rd_en leaves src_idx=4, and done forces wr_full=1.
REQ-040 Reset mid-transfer: assert rst after 10 words; all outputs SHALL return to reset values asynchronously, and a full loopback then completes with error_count=0.
